// File: rtl/mux_arb.sv
// ---------------------------------------------------------------------------
// mux_arb -- N-input arbitrating multiplexer with a single registered output.
//
// Up to nports producers compete for one output register. Each cycle an
// arbiter picks at most one requesting port. That port's message is loaded
// into the output register, which holds exactly one entry (EMPTY / FULL).
//
// Build option:
//   MUX_ARB_RR_EN defined   -> round-robin. The search starts at ptr, which
//                              advances past the last accepted port.
//   MUX_ARB_RR_EN undefined -> fixed priority. The lowest requesting index
//                              wins, and no pointer register exists.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_val     [nports]        per-port request (message valid)
//   in_rdy     [nports]        per-port accept; at most one bit is high
//   in_msg     [nports*nbits]  port i message in bits [i*nbits +: nbits]
//   out_val                    output register holds a message
//   out_rdy                    consumer takes out_msg this cycle
//   out_msg    [nbits]         registered message
//   dbg_state                  FSM state (0 = EMPTY, 1 = FULL)
//
// Handshake: on every interface a transfer happens in exactly the cycle
// where val and rdy are both 1. A producer may raise or drop val at any
// time. Nothing is recorded for a val that is withdrawn before it sees rdy.
// in_rdy never depends on in_msg.
// ---------------------------------------------------------------------------
module mux_arb #(
  parameter int nbits  = 32,
  parameter int nports = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [nports-1:0]       in_val,
  output logic [nports-1:0]       in_rdy,
  input  logic [nports*nbits-1:0] in_msg,
  output logic                    out_val,
  input  logic                    out_rdy,
  output logic [nbits-1:0]        out_msg,
  output logic                    dbg_state
);

  localparam int PW  = (nports > 1) ? $clog2(nports) : 1;
  // One extra bit so that ptr + offset can exceed nports before wrapping.
  localparam int PW1 = PW + 1;

  localparam logic [0:0] STATE_EMPTY = 1'b0;
  localparam logic [0:0] STATE_FULL  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [nbits-1:0] msg_q, msg_d;
  logic [PW-1:0]    ptr_cur;

  logic [nports-1:0] grant;
  logic [PW-1:0]     gidx;
  logic              found;
  logic [PW1-1:0]    idx;
  logic              space;
  logic              in_fire;
  logic              out_fire;
  logic [nbits-1:0]  sel_msg;

  // -------------------------------------------------------------------------
  // Arbiter: walk upward from ptr, wrapping at nports. Take the first
  // requesting port. nports need not be a power of two, so the wrap is an
  // explicit subtract rather than a natural overflow.
  // -------------------------------------------------------------------------
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < nports; k++) begin
      idx = {1'b0, ptr_cur} + PW1'(k);
      if (idx >= PW1'(nports)) begin
        idx = idx - PW1'(nports);
      end
      if (!found && in_val[idx[PW-1:0]]) begin
        found             = 1'b1;
        gidx              = idx[PW-1:0];
        grant[idx[PW-1:0]] = 1'b1;
      end
    end
  end

  // Room to load when empty, or when the current entry leaves this cycle.
  assign space = (state_q == STATE_EMPTY) || out_rdy;

  // in_rdy is forced low during reset so that nothing is accepted while
  // the register is being cleared.
  assign in_rdy   = rst ? '0 : (grant & {nports{space}});
  assign in_fire  = |in_rdy;
  assign out_fire = (state_q == STATE_FULL) && out_rdy;

  assign sel_msg = in_msg[int'(gidx)*nbits +: nbits];

  // -------------------------------------------------------------------------
  // Output entry FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    if (in_fire) begin
      // Covers both a load into EMPTY and a same-cycle replace while FULL.
      state_d = STATE_FULL;
      msg_d   = sel_msg;
    end else if (out_fire) begin
      state_d = STATE_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STATE_EMPTY;
      msg_q   <= '0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
    end
  end

  // -------------------------------------------------------------------------
  // Arbitration pointer
  // -------------------------------------------------------------------------
`ifdef MUX_ARB_RR_EN
  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (in_fire) begin
      ptr_d = (gidx == PW'(nports - 1)) ? '0 : gidx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_cur = ptr_q;
`else
  assign ptr_cur = '0;
`endif

  assign out_val   = (state_q == STATE_FULL);
  assign out_msg   = msg_q;
  assign dbg_state = state_q;

endmodule

// File: doc/mux_arb.md
MUX_ARB -- requirements
Module: mux_arb

Interface
REQ-001: Parameter nbits, default 32, SHALL set the message width per port.
REQ-002: Parameter nports, default 4, SHALL set the input channel count; legal range 2..16, power of two not required.
REQ-003: clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004: rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005: in_val  input  nports  SHALL flag bit i as a valid message on port i.
REQ-006: in_rdy  output  nports  SHALL flag bit i as port i being accepted this cycle.
REQ-007: in_msg  input  nports*nbits  SHALL carry port i's message in bits [i*nbits +: nbits].
REQ-008: out_val  output  1  SHALL flag the output register as holding a message.
REQ-009: out_rdy  input  1  SHALL flag the consumer accepting out_msg this cycle.
REQ-010: out_msg  output  nbits  SHALL be the registered message.

Function
REQ-011: A transfer SHALL occur on any interface in a cycle where its val and rdy are both 1.
REQ-012: The block SHALL hold one output entry with two states, EMPTY (out_val=0) and FULL (out_val=1).
REQ-013: Grant SHALL be one-hot or zero; it is zero when in_val is all zeros.
REQ-014: Grant SHALL select the first asserted in_val at or after index ptr, searching upward and wrapping from nports-1 to 0.
REQ-015: The block SHALL compute space = (state==EMPTY) || out_rdy.
REQ-016: The block SHALL drive in_rdy[i] = grant[i] && space; at most one in_rdy bit is high per cycle.
REQ-017: in_rdy SHALL depend combinationally on in_val, ptr, state and out_rdy only, never on in_msg.
REQ-018: On an input transfer from port g, out_msg SHALL load in_msg[g], state SHALL become FULL, and latency SHALL be exactly 1 cycle.
REQ-019: On an output transfer with no input transfer in the same cycle, state SHALL become EMPTY and out_msg SHALL hold its value.
REQ-020: A simultaneous output and input transfer SHALL keep the state FULL and load the new message, sustaining 1 message/cycle.
REQ-021: While out_val=1 and out_rdy=0, out_msg and out_val SHALL stay stable, and in_rdy SHALL be all zeros (backpressure).
REQ-022: ptr SHALL be ceil(log2(nports)) bits wide; after an input transfer from port g it SHALL become (g+1) mod nports, wrapping from nports-1 to 0.
REQ-023: ptr SHALL be unchanged in any cycle without an input transfer.
REQ-024: A port that drops in_val before being granted SHALL have nothing recorded and SHALL not affect ptr.

Reset
REQ-025: While rst=1, state SHALL be EMPTY, out_val SHALL be 0, out_msg SHALL be 0 and ptr SHALL be 0.
REQ-026: in_rdy SHALL be all zeros during any cycle with rst=1.
REQ-027: A rst asserted while FULL SHALL drop the buffered message with no output transfer.
REQ-028: The block SHALL accept normally on the first cycle after rst deasserts.

Configuration
REQ-029: Macro MUX_ARB_RR_EN defined SHALL give round-robin grant per REQ-014 and REQ-022.
REQ-030: Macro MUX_ARB_RR_EN undefined SHALL give fixed priority: ptr is held at 0, the lowest asserted index wins, and the pointer register is not built.

Verification
REQ-031: rst 2 cycles, then idle -> out_val=0, out_msg=0, in_rdy=0000.
REQ-032: in_val=0100, in_msg[2]=0xDEADBEEF, out_rdy=1 -> in_rdy=0100 that cycle; next cycle out_val=1, out_msg=0xDEADBEEF.
REQ-033: RR build; in_val=1111 held for 5 cycles, out_rdy=1 -> grant order 0,1,2,3,0; ptr wraps 3->0. Fixed-priority build: grant 0 every cycle.
REQ-034: FULL with out_msg=0x11, out_rdy=0 for 3 cycles, in_val=0010 -> in_rdy=0000 and out_msg=0x11 stable; out_rdy=1 -> port 1 accepted in the same cycle, out_msg updates next cycle.
REQ-035: FULL with out_msg=0x22, rst=1 for one cycle -> out_val=0 next cycle, no output transfer counted, ptr=0.
REQ-036: nports=3, in_val=101, ptr=1 (RR) -> grant port 2; next grant port 0 after ptr wraps to 0.
